// File: rtl/divide_unit_if.sv
// divide_unit_if: request/result bundle between the control unit, register file ports and the divider.
// Request (master->slave): start, flush, op, rs1_data, rs2_data, rd_addr_in.
// Result  (slave->master): busy, done, rf_wr_en, rd_addr, wr_data.
interface divide_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr_in;
    logic            busy;
    logic            done;
    logic            rf_wr_en;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output start, flush, op, rs1_data, rs2_data, rd_addr_in,
        input  busy, done, rf_wr_en, rd_addr, wr_data
    );

    modport slave (
        input  start, flush, op, rs1_data, rs2_data, rd_addr_in,
        output busy, done, rf_wr_en, rd_addr, wr_data
    );
endinterface

// File: rtl/divide_unit.sv
// divide_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk, res (sync active-high reset), bus (divide_unit_if.slave: start/flush/op/operands/rd in,
//        busy/done/rf_wr_en/rd_addr/wr_data out, all registered).
// Optional: define DIVIDE_UNIT_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module divide_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         res,
    divide_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int CW = $clog2(XLEN + 1);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dvz_q, dvz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic            a_neg, b_neg, dvz_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n;
`ifdef DIVIDE_UNIT_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            ovf_in;
`endif

    // Select quotient or remainder, restore the sign, and apply the divide-by-zero result.
    // Signed overflow needs no special case: |MIN| wraps to MIN and the signs cancel.
    function automatic logic [XLEN-1:0] fixup(
        input logic [1:0]      f_op,
        input logic [XLEN-1:0] f_rem,
        input logic [XLEN-1:0] f_quo,
        input logic [XLEN-1:0] f_a,
        input logic            f_qneg,
        input logic            f_rneg,
        input logic            f_dvz
    );
        logic [XLEN-1:0] v;
        v = f_op[1] ? f_rem : f_quo;
        v = (f_op[1] ? f_rneg : f_qneg) ? -v : v;
        return f_dvz ? (f_op[1] ? f_a : '1) : v;
    endfunction

    always_comb begin
        a_neg  = !bus.op[0] & bus.rs1_data[XLEN-1];
        b_neg  = !bus.op[0] & bus.rs2_data[XLEN-1];
        a_mag  = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag  = b_neg ? -bus.rs2_data : bus.rs2_data;
        dvz_in = bus.rs2_data == '0;
`ifdef DIVIDE_UNIT_EARLY_OUT_EN
        ovf_in = a_neg && bus.rs1_data == MIN && bus.rs2_data == '1;
`endif
        // Shifted partial remainder is XLEN+1 bits; borrow out (diff[XLEN]) means it is below the divisor.
        diff  = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
        ge    = !diff[XLEN];
        rem_n = ge ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_n = {quo_q[XLEN-2:0], ge};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        div_d     = div_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvz_d     = dvz_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        rd_out_d  = rd_out_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                op_d    = bus.op;
                rd_d    = bus.rd_addr_in;
                a_d     = bus.rs1_data;
                div_d   = b_mag;
                rem_d   = '0;
                quo_d   = a_mag;
                cnt_d   = CW'(XLEN);
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dvz_d   = dvz_in;
                state_d = CALC;
`ifdef DIVIDE_UNIT_EARLY_OUT_EN
                if (dvz_in || ovf_in) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    wr_en_d   = bus.rd_addr_in != 5'd0;
                    rd_out_d  = bus.rd_addr_in;
                    wr_data_d = fixup(bus.op, '0, a_mag, bus.rs1_data, a_neg ^ b_neg, a_neg, dvz_in);
                end
`endif
            end
            CALC: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q - 1'b1;
                // The result is formed on the final iteration so done/wr_data are registered into DONE.
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    wr_en_d   = rd_q != 5'd0;
                    rd_out_d  = rd_q;
                    wr_data_d = fixup(op_q, rem_n, quo_n, a_q, qneg_q, rneg_q, dvz_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush && state_q != IDLE) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            wr_en_d   = 1'b0;
            rd_out_d  = rd_out_q;
            wr_data_d = wr_data_q;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dvz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_out_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dvz_q     <= dvz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            rd_out_q  <= rd_out_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rf_wr_en = wr_en_q;
    assign bus.rd_addr  = rd_out_q;
    assign bus.wr_data  = wr_data_q;
endmodule

// File: doc/divide_unit.md
# divide_unit

Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits between the register file read ports and the register file write port:
- It captures rs1/rs2 operand data and the destination register when `start` is asserted.
- It computes one quotient bit per cycle.
- It drives a single-cycle write-back (`rf_wr_en`, `rd_addr`, `wr_data`) that connects directly to the register file write port.
- The control unit stalls the core while `busy` is high.

## Interface
- `XLEN`, default 32: operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `res`  in  1  synchronous, active-high reset.
- `start`  in  1  request a divide; sampled only in IDLE.
- `flush`  in  1  abort the in-flight operation (synchronous).
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data`  in  XLEN  dividend.
- `rs2_data`  in  XLEN  divisor.
- `rd_addr_in`  in  5  destination register, latched with operands.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `rf_wr_en`  out  1  register file write enable: `done` and latched rd != 0.
- `rd_addr`  out  5  latched destination.
- `wr_data`  out  XLEN  quotient or remainder.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: runs iterations.
  - DONE: presents the result.
  - Transitions: IDLE→CALC on `start`; CALC→DONE after `XLEN` iterations; DONE→IDLE unconditionally.
- Start in IDLE:
  - Latch op, rd, signedness and the operand magnitudes (absolute values for DIV/REM).
  - Record the quotient sign: dividend sign XOR divisor sign.
  - Record the remainder sign: dividend sign.
  - Clear the partial remainder and load the iteration counter with `XLEN`.
- CALC, restoring algorithm, once per cycle:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor, subtract the divisor and set quo[0].
  - Use an XLEN+1-bit subtract to avoid overflow.
  - Decrement the counter; leave CALC when it reaches 0.
- DONE:
  - Select quo (DIV/DIVU) or rem (REM/REMU) and apply the sign fix-up (two's-complement negate) for signed ops.
  - Register the result onto `wr_data`; assert `done` and `rf_wr_en` for exactly one cycle.
- Special results (RISC-V spec; identical with or without the configuration macro):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (DIV of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1), remainder = 0.
- `start` while `busy`: ignored; latched operands are unchanged.
- `flush` in CALC or DONE:
  - Next state is IDLE; `done` and `rf_wr_en` are forced to 0 in the same cycle.
  - `flush` takes priority over `start` and over completion.
- `res`: all state and outputs go to zero on the next edge; state becomes IDLE. Takes priority over everything, including mid-operation.
- rd = 0: the operation runs normally and `done` pulses, but `rf_wr_en` stays 0.

## Timing
- All outputs are registered. Reset values: `busy`=0, `done`=0, `rf_wr_en`=0, `rd_addr`=0, `wr_data`=0.
- Normal latency: `start` sampled high in cycle 0 → `busy` high from cycle 1 → `done` high in cycle XLEN+1 (cycle 33 for XLEN=32) → `busy` low in cycle XLEN+2.
- A new `start` is accepted in the same cycle `busy` drops, i.e. back-to-back with one IDLE cycle.
- `wr_data` and `rd_addr` hold their values after `done` until the next DONE.
- `rs1_data`, `rs2_data`, `op` and `rd_addr_in` may change freely after the start cycle.

## Configuration
- `DIVIDE_UNIT_EARLY_OUT_EN`:
  - Defined: divide-by-zero and signed overflow are detected in the start cycle. The FSM goes IDLE→DONE directly, so `done` is high in cycle 1.
  - Undefined: these cases run the full `XLEN` iterations (`done` in cycle XLEN+1), with result values forced by the DONE-state special-case logic.
  - Result values are identical in both builds.

## Test plan
- DIVU 100/7, rd=5, start cycle 0 → cycle 33: `done`=1, `rf_wr_en`=1, `rd_addr`=5, `wr_data`=14; REMU with the same operands → `wr_data`=2.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIV 7/-2 → 0xFFFFFFFD; REM 7/-2 → 1.
- DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. `done` in cycle 1 with `DIVIDE_UNIT_EARLY_OUT_EN`, cycle 33 without.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0 (both builds; latency as above).
- DIVU 50/5 at cycle 0, then `start` with 9/3 at cycle 10 (ignored), then `flush` at cycle 20:
  - `busy` is 0 in cycle 21 and no `done` is produced.
  - `start` with 9/3 in cycle 22 → `wr_data`=3 in cycle 55.
- `res` in cycle 15 mid-CALC → all outputs 0 in cycle 16, no `done`. DIVU 8/2 with rd=0 → `done`=1, `rf_wr_en`=0, `wr_data`=4.
